// File: rtl/flash_audio_reader.sv
// Flash-to-audio word feeder: fetches one 32-bit word at a time over Avalon-MM and
// hands it to the audio FSM with a start/finish handshake, walking the address with wrap.
module flash_audio_reader #(
  parameter int              ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_en,
  input  logic              dir_fwd,
  input  logic              restart,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [31:0]       audio_data,
  output logic              audio_start,
  input  logic              audio_finish
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_D,
    S_START,
    S_WAIT_F,
    S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              restart_pend_q, restart_pend_d;
  logic              audio_start_q, audio_start_d;
  logic              pend_any;
  logic [ADDR_W-1:0] start_addr;

  // A restart arriving in the very cycle it is consumed still counts.
  assign pend_any   = restart_pend_q | restart;
  assign start_addr = dir_fwd ? '0 : MAX_ADDR;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    restart_pend_d = pend_any;
    audio_start_d  = (state_q == S_START);

    unique case (state_q)
      S_IDLE: begin
        if (pend_any) begin
          addr_d         = start_addr;
          restart_pend_d = 1'b0;
        end
        if (play_en) state_d = S_REQ;
      end
      S_REQ: begin
        if (!flash_mem_waitrequest) state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (flash_mem_readdatavalid) begin
          data_d  = flash_mem_readdata;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_F;
      end
      S_WAIT_F: begin
        if (audio_finish) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (pend_any) begin
          addr_d         = start_addr;
          restart_pend_d = 1'b0;
        end else if (dir_fwd) begin
          addr_d = (addr_q == MAX_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end else begin
          addr_d = (addr_q == '0) ? MAX_ADDR : addr_q - ADDR_W'(1);
        end
        state_d = play_en ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      restart_pend_q <= 1'b0;
      audio_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      restart_pend_q <= restart_pend_d;
      audio_start_q  <= audio_start_d;
    end
  end

  // audio_start is registered off START, giving the two-cycle rdvalid-to-start latency.
  assign flash_mem_read       = (state_q == S_REQ);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'hF;
  assign audio_data           = data_q;
  assign audio_start          = audio_start_q;

endmodule

// File: tb/tb_flash_audio_reader.sv
// Randomized bench: behavioural flash and audio-consumer models plus an address/data
// reference model for flash_audio_reader.
module tb_flash_audio_reader;

  localparam int          ADDR_W   = 23;
  localparam logic [22:0] MAX_ADDR = 23'h7FFFF;
  localparam int          RDV_LAT  = 2;
  localparam int          BOUND    = 20000;

  logic        clk, reset, play_en, dir_fwd, restart;
  logic        flash_mem_read, flash_mem_waitrequest, flash_mem_readdatavalid;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata, audio_data;
  logic        audio_start, audio_finish;

  flash_audio_reader #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .play_en                 (play_en),
    .dir_fwd                 (dir_fwd),
    .restart                 (restart),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_data              (audio_data),
    .audio_start             (audio_start),
    .audio_finish            (audio_finish)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  logic [22:0] exp_addr;
  bit          m_pend, m_idle;
  // Flash model state
  bit          in_req, acc_armed, acc_seen, wr_rand;
  int          wr_left, wr_fix, rdv_cnt, rdv_call;
  logic [22:0] req_addr;
  logic [31:0] rdv_word;
  logic [31:0] q_data[$];
  logic [22:0] q_addr[$];
  // Audio consumer state
  bit          busy, start_evt;
  int          fin_cnt, fin_max;
  logic [31:0] cur_data;
  logic [22:0] cur_addr;

  function automatic logic [22:0] next_addr(input logic [22:0] a, input logic fwd);
    int unsigned span = int'(MAX_ADDR) + 1;
    int unsigned ua   = int'(a);
    return fwd ? 23'((ua + 1) % span) : 23'((ua + span - 1) % span);
  endfunction

  task automatic monitor();
    audio_finish            = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    start_evt               = 1'b0;
    if (acc_armed) begin
      acc_armed = 1'b0;
      acc_seen  = 1'b1;
    end
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = rdv_word;
        rdv_call                = cyc;
      end
    end
    if (flash_mem_read) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = flash_mem_address;
        wr_left  = wr_rand ? int'($urandom_range(0, 5)) : wr_fix;
        check("req_addr", flash_mem_address, exp_addr);
        check("one_in_flight", {busy, q_data.size() != 0, m_idle}, 3'b000);
      end else begin
        check("hold_addr", flash_mem_address, req_addr);
      end
      if (wr_left > 0) begin
        flash_mem_waitrequest = 1'b1;
        wr_left--;
      end else begin
        flash_mem_waitrequest = 1'b0;
        in_req    = 1'b0;
        acc_armed = 1'b1;
        rdv_word  = $urandom;
        q_data.push_back(rdv_word);
        q_addr.push_back(req_addr);
        rdv_cnt   = RDV_LAT;
      end
    end else begin
      if (in_req) check("read_dropped_in_stall", in_req, 1'b0);
      in_req = 1'b0;
      flash_mem_waitrequest = 1'b0;
    end
    if (audio_start) begin
      check("start_lat", cyc, rdv_call + RDV_LAT);
      check("start_busy", busy, 1'b0);
      check("start_pending", q_data.size(), 1);
      if (q_data.size() > 0) begin
        cur_data = q_data.pop_front();
        cur_addr = q_addr.pop_front();
        check("audio_data", audio_data, cur_data);
      end
      busy      = 1'b1;
      start_evt = 1'b1;
      fin_cnt   = $urandom_range(1, fin_max);
    end else if (busy) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        check("data_hold", audio_data, cur_data);
        audio_finish = 1'b1;
        busy         = 1'b0;
        if (m_pend) begin
          exp_addr = dir_fwd ? 23'd0 : MAX_ADDR;
          m_pend   = 1'b0;
        end else begin
          exp_addr = next_addr(exp_addr, dir_fwd);
        end
        if (!play_en) m_idle = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_word(input logic [22:0] target);
    int t = 0;
    do begin
      tick();
      t++;
    end while (!(start_evt && cur_addr == target) && t < BOUND);
    check("word_reached", {start_evt, cur_addr}, {1'b1, target});
  endtask

  task automatic do_restart();
    restart = 1'b1;
    if (m_idle) exp_addr = dir_fwd ? 23'd0 : MAX_ADDR;
    else        m_pend   = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic pause_check();
    int t = 0;
    while (!m_idle && t < BOUND) begin
      tick();
      t++;
    end
    check("idle_reached", m_idle, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_read", flash_mem_read, 1'b0);
      check("idle_addr", flash_mem_address, exp_addr);
    end
  endtask

  initial begin
    reset = 1'b1; play_en = 1'b0; dir_fwd = 1'b1; restart = 1'b0;
    flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = '0; audio_finish = 1'b0;
    exp_addr = '0; m_pend = 0; m_idle = 1; in_req = 0; acc_armed = 0; acc_seen = 0;
    wr_rand = 0; wr_fix = 0; rdv_cnt = 0; rdv_call = -100; busy = 0; fin_max = 3;
    cur_addr = '0; cur_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_read", flash_mem_read, 1'b0);
    check("rst_addr", flash_mem_address, 23'd0);
    check("rst_data", audio_data, 32'd0);
    check("rst_start", audio_start, 1'b0);
    check("byteenable", flash_mem_byteenable, 4'hF);

    // Forward streaming, zero-wait flash
    play_en = 1'b1; m_idle = 1'b0;
    wait_word(23'd2);
    // Long stalls, then random stalls and consumer delays
    wr_fix = 5;
    wait_word(23'd4);
    wr_rand = 1; fin_max = 6;
    wait_word(23'h20);
    // Pause mid-word, then resume at the following word
    play_en = 1'b0;
    pause_check();
    play_en = 1'b1; m_idle = 1'b0;
    wait_word(23'h21);
    // Fast walk, restart forward from 0x100
    wr_rand = 0; wr_fix = 0; fin_max = 1;
    wait_word(23'h100);
    do_restart();
    wait_word(23'd0);
    // Backward wrap, then forward wrap
    dir_fwd = 1'b0;
    wait_word(MAX_ADDR);
    wait_word(MAX_ADDR - 23'd1);
    dir_fwd = 1'b1; fin_max = 4;
    wait_word(MAX_ADDR);
    wait_word(23'd0);
    wait_word(23'd1);
    // Restart while playing backward
    dir_fwd = 1'b0;
    do_restart();
    wait_word(MAX_ADDR);
    // Pause, then restart while idle
    play_en = 1'b0;
    pause_check();
    dir_fwd = 1'b1;
    do_restart();
    tick();
    tick();
    check("idle_restart_addr", flash_mem_address, 23'd0);
    play_en = 1'b1; m_idle = 1'b0;
    wait_word(23'd0);

    // Reset while waiting for read data; late rdvalid must be ignored
    wr_fix = 0; acc_seen = 0;
    for (int t = 0; t < BOUND && !acc_seen; t++) tick();
    check("accept_seen", acc_seen, 1'b1);
    play_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    q_data.delete(); q_addr.delete();
    busy = 0; in_req = 0; exp_addr = '0; m_pend = 0; m_idle = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_start", audio_start, 1'b0);
      check("post_rst_data", audio_data, 32'd0);
      check("post_rst_addr", flash_mem_address, 23'd0);
      check("post_rst_read", flash_mem_read, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
